// File: rtl/capture_controller.sv
// Logic-analyzer capture controller: arms a prescaled sampler, waits for a masked
// trigger match, stores a post-trigger window into a circular sample buffer.
module capture_controller #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic [28:0]       cfg_factor,
  input  logic [ADDR_W-1:0] cfg_post,
  input  logic [DATA_W-1:0] trig_mask,
  input  logic [DATA_W-1:0] trig_value,
  input  logic [DATA_W-1:0] din,
  input  logic              ce,
  output logic [28:0]       presc_factor,
  output logic              presc_rst,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              busy,
  output logic              done
);

  localparam int unsigned FACT_W = 29;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_busy;
  logic                r_done;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic                r_fin;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W-1:0]   r_left;
  logic [ADDR_W-1:0]   r_post;
  logic [FACT_W-1:0]   r_factor;
  logic                r_presc_rst;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic [ADDR_W-1:0]   r_trig_addr;

  logic w_active;
  logic w_arm_ok;
  logic w_sample;
  logic w_match;
  logic w_trig;
  logic w_last;

  // r_fin marks the one-cycle gap between the final sample and DONE, so done
  // trails the last write pulse; samples are ignored during that gap.
  assign w_active = (r_state == S_ARMED) || (r_state == S_POST);
  assign w_arm_ok = arm && !abort && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_sample = ce && w_active && !r_fin && !abort;
  assign w_match  = ((din ^ trig_value) & trig_mask) == '0;
  assign w_trig   = w_sample && (r_state == S_ARMED) && w_match;
  assign w_last   = (w_trig && (r_post == '0)) ||
                    (w_sample && (r_state == S_POST) && (r_left == ADDR_W'(1)));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (arm) w_next = S_ARMED;
        S_ARMED: begin
          if (r_fin)                          w_next = S_DONE;
          else if (w_trig && (r_post != '0))  w_next = S_POST;
        end
        S_POST:  if (r_fin) w_next = S_DONE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Status outputs follow the state being entered
  always_comb begin
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    case (w_next)
      S_ARMED, S_POST: w_busy_nxt = 1'b1;
      S_DONE:          w_done_nxt = 1'b1;
      default: ;
    endcase
  end

  // Capture datapath: pointer, write port, trigger address, prescaler config
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fin       <= 1'b0;
      r_ptr       <= '0;
      r_left      <= '0;
      r_post      <= '0;
      r_factor    <= FACT_W'(1);
      r_presc_rst <= 1'b1;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_trig_addr <= '0;
    end else begin
      r_presc_rst <= w_arm_ok;
      r_wr_en     <= w_sample;
      r_fin       <= w_last;
      if (w_arm_ok) begin
        r_factor  <= (cfg_factor == '0) ? FACT_W'(1) : cfg_factor;
        r_post    <= cfg_post;
        r_ptr     <= '0;
        r_wr_addr <= '0;
      end
      if (w_sample) begin
        r_wr_data <= din;
        r_wr_addr <= r_ptr;
        r_ptr     <= r_ptr + ADDR_W'(1);
        if (w_trig) begin
          r_trig_addr <= r_ptr;
          r_left      <= r_post;
        end else if (r_state == S_POST) begin
          r_left <= r_left - ADDR_W'(1);
        end
      end
    end
  end

  assign presc_factor = r_factor;
  assign presc_rst    = r_presc_rst;
  assign wr_en        = r_wr_en;
  assign wr_addr      = r_wr_addr;
  assign wr_data      = r_wr_data;
  assign trig_addr    = r_trig_addr;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule
